// File: rtl/control_sequencer.sv
// control_sequencer: Moore-style control unit for a simple bus-based CPU.
// A fetch prologue (T0..T2) is followed by a DEC dispatch into the ld, ldi,
// st or br microsequences; halt parks the machine until clr.
module control_sequencer (
    input  logic       clk,
    input  logic       clr,
    input  logic [4:0] operation,
    input  logic       con_ff,
    output logic       PCout,
    output logic       PCin,
    output logic       IncPC,
    output logic       MARin,
    output logic       MDRin,
    output logic       MDRout,
    output logic       Read,
    output logic       RAM_write_en,
    output logic       IRin,
    output logic       Yin,
    output logic       ZHighIn,
    output logic       ZLowIn,
    output logic       ZLowout,
    output logic       Cout,
    output logic       Gra,
    output logic       Grb,
    output logic       R_in,
    output logic       R_out,
    output logic       Baout,
    output logic       enableCon,
    output logic       alu_add,
    output logic       run
);

    typedef enum logic [4:0] {
        S_RST,
        S_T0,
        S_T1,
        S_T2,
        S_DEC,
        S_LD3,
        S_LD4,
        S_LD5,
        S_LD6,
        S_LD7,
        S_LDI3,
        S_LDI4,
        S_LDI5,
        S_ST3,
        S_ST4,
        S_ST5,
        S_ST6,
        S_ST7,
        S_BR3,
        S_BR4,
        S_BR5,
        S_BR6,
        S_HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    state_t state_q;
    state_t state_d;

    // State register; clr forces RST from any state, including HALT.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fixed microsequences, opcode only consulted in DEC.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:  state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = S_T2;
            S_T2:   state_d = S_DEC;
            S_DEC: begin
                case (operation)
                    OP_LD:   state_d = S_LD3;
                    OP_LDI:  state_d = S_LDI3;
                    OP_ST:   state_d = S_ST3;
                    OP_BR:   state_d = S_BR3;
                    OP_HALT: state_d = S_HALT;
                    default: state_d = S_T0;
                endcase
            end
            S_LD3:  state_d = S_LD4;
            S_LD4:  state_d = S_LD5;
            S_LD5:  state_d = S_LD6;
            S_LD6:  state_d = S_LD7;
            S_LD7:  state_d = S_T0;
            S_LDI3: state_d = S_LDI4;
            S_LDI4: state_d = S_LDI5;
            S_LDI5: state_d = S_T0;
            S_ST3:  state_d = S_ST4;
            S_ST4:  state_d = S_ST5;
            S_ST5:  state_d = S_ST6;
            S_ST6:  state_d = S_ST7;
            S_ST7:  state_d = S_T0;
            S_BR3:  state_d = S_BR4;
            S_BR4:  state_d = S_BR5;
            S_BR5:  state_d = S_BR6;
            S_BR6:  state_d = S_T0;
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    // Output decode: every strobe is a function of state alone, except the
    // conditional PC load in BR6 which follows con_ff directly.
    always_comb begin
        PCout        = 1'b0;
        PCin         = 1'b0;
        IncPC        = 1'b0;
        MARin        = 1'b0;
        MDRin        = 1'b0;
        MDRout       = 1'b0;
        Read         = 1'b0;
        RAM_write_en = 1'b0;
        IRin         = 1'b0;
        Yin          = 1'b0;
        ZHighIn      = 1'b0;
        ZLowIn       = 1'b0;
        ZLowout      = 1'b0;
        Cout         = 1'b0;
        Gra          = 1'b0;
        Grb          = 1'b0;
        R_in         = 1'b0;
        R_out        = 1'b0;
        Baout        = 1'b0;
        enableCon    = 1'b0;
        alu_add      = 1'b0;
        run          = 1'b1;
        case (state_q)
            S_T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                ZHighIn = 1'b1;
                ZLowIn  = 1'b1;
            end
            S_T1: begin
                Read    = 1'b1;
                MDRin   = 1'b1;
                ZLowout = 1'b1;
                PCin    = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_LD3, S_LDI3, S_ST3: begin
                Grb   = 1'b1;
                Baout = 1'b1;
                Yin   = 1'b1;
            end
            S_LD4, S_LDI4, S_ST4, S_BR5: begin
                Cout    = 1'b1;
                alu_add = 1'b1;
                ZHighIn = 1'b1;
                ZLowIn  = 1'b1;
            end
            S_LD5, S_ST5: begin
                ZLowout = 1'b1;
                MARin   = 1'b1;
            end
            S_LD6: begin
                Read  = 1'b1;
                MDRin = 1'b1;
            end
            S_LD7: begin
                MDRout = 1'b1;
                Gra    = 1'b1;
                R_in   = 1'b1;
            end
            S_LDI5: begin
                ZLowout = 1'b1;
                Gra     = 1'b1;
                R_in    = 1'b1;
            end
            S_ST6: begin
                Gra   = 1'b1;
                R_out = 1'b1;
                MDRin = 1'b1;
            end
            S_ST7: begin
                RAM_write_en = 1'b1;
            end
            S_BR3: begin
                Gra       = 1'b1;
                R_out     = 1'b1;
                enableCon = 1'b1;
            end
            S_BR4: begin
                PCout = 1'b1;
                Yin   = 1'b1;
            end
            S_BR6: begin
                ZLowout = 1'b1;
                PCin    = con_ff;
            end
            S_HALT: begin
                run = 1'b0;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized bench with a microprogram-table reference
// model. Each instruction expands to a list of expected control words.
module tb_control_sequencer;

    logic       clk;
    logic       clr;
    logic [4:0] operation;
    logic       con_ff;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, RAM_write_en, IRin, Yin;
    logic ZHighIn, ZLowIn, ZLowout, Cout, Gra, Grb, R_in, R_out, Baout, enableCon;
    logic alu_add, run;

    control_sequencer dut (
        .clk(clk), .clr(clr), .operation(operation), .con_ff(con_ff),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .Read(Read), .RAM_write_en(RAM_write_en), .IRin(IRin),
        .Yin(Yin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn), .ZLowout(ZLowout),
        .Cout(Cout), .Gra(Gra), .Grb(Grb), .R_in(R_in), .R_out(R_out),
        .Baout(Baout), .enableCon(enableCon), .alu_add(alu_add), .run(run)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word bit masks; bits 22/23 are model-only tags.
    localparam logic [23:0] M_PCOUT = 24'h1 << 0;
    localparam logic [23:0] M_PCIN  = 24'h1 << 1;
    localparam logic [23:0] M_INCPC = 24'h1 << 2;
    localparam logic [23:0] M_MARIN = 24'h1 << 3;
    localparam logic [23:0] M_MDRIN = 24'h1 << 4;
    localparam logic [23:0] M_MDROUT= 24'h1 << 5;
    localparam logic [23:0] M_READ  = 24'h1 << 6;
    localparam logic [23:0] M_WR    = 24'h1 << 7;
    localparam logic [23:0] M_IRIN  = 24'h1 << 8;
    localparam logic [23:0] M_YIN   = 24'h1 << 9;
    localparam logic [23:0] M_ZHI   = 24'h1 << 10;
    localparam logic [23:0] M_ZLI   = 24'h1 << 11;
    localparam logic [23:0] M_ZLOUT = 24'h1 << 12;
    localparam logic [23:0] M_COUT  = 24'h1 << 13;
    localparam logic [23:0] M_GRA   = 24'h1 << 14;
    localparam logic [23:0] M_GRB   = 24'h1 << 15;
    localparam logic [23:0] M_RIN   = 24'h1 << 16;
    localparam logic [23:0] M_ROUT  = 24'h1 << 17;
    localparam logic [23:0] M_BAOUT = 24'h1 << 18;
    localparam logic [23:0] M_ECON  = 24'h1 << 19;
    localparam logic [23:0] M_ADD   = 24'h1 << 20;
    localparam logic [23:0] M_RUN   = 24'h1 << 21;
    localparam logic [23:0] M_COND  = 24'h1 << 22;
    localparam logic [23:0] M_DEC   = 24'h1 << 23;

    localparam logic [23:0] W_RST  = M_RUN;
    localparam logic [23:0] W_T0   = M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZHI | M_ZLI;
    localparam logic [23:0] W_T1   = M_RUN | M_READ | M_MDRIN | M_ZLOUT | M_PCIN;
    localparam logic [23:0] W_T2   = M_RUN | M_MDROUT | M_IRIN;
    localparam logic [23:0] W_DEC  = M_RUN | M_DEC;
    localparam logic [23:0] W_GBY  = M_RUN | M_GRB | M_BAOUT | M_YIN;
    localparam logic [23:0] W_CADD = M_RUN | M_COUT | M_ADD | M_ZHI | M_ZLI;
    localparam logic [23:0] W_ZMAR = M_RUN | M_ZLOUT | M_MARIN;
    localparam logic [23:0] W_LD6  = M_RUN | M_READ | M_MDRIN;
    localparam logic [23:0] W_LD7  = M_RUN | M_MDROUT | M_GRA | M_RIN;
    localparam logic [23:0] W_LDI5 = M_RUN | M_ZLOUT | M_GRA | M_RIN;
    localparam logic [23:0] W_ST6  = M_RUN | M_GRA | M_ROUT | M_MDRIN;
    localparam logic [23:0] W_ST7  = M_RUN | M_WR;
    localparam logic [23:0] W_BR3  = M_RUN | M_GRA | M_ROUT | M_ECON;
    localparam logic [23:0] W_BR4  = M_RUN | M_PCOUT | M_YIN;
    localparam logic [23:0] W_BR6  = M_RUN | M_ZLOUT | M_COND;
    localparam logic [23:0] W_HALT = 24'h0;

    int n_checks;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic [23:0] q[$];
    bit          halted;
    int          halt_cnt;
    int          halt_len;
    bit          clr_at_ld5;
    int          con_mode;   // 0 random, 1 force 0, 2 force 1

    // Expand one dispatched opcode into its expected control words.
    task automatic dispatch(input logic [4:0] op, input bit directed);
        case (op)
            5'b00000: q = {q, W_GBY, W_CADD, W_ZMAR, W_LD6, W_LD7};
            5'b00001: q = {q, W_GBY, W_CADD, W_LDI5};
            5'b00010: q = {q, W_GBY, W_CADD, W_ZMAR, W_ST6, W_ST7};
            5'b10010: q = {q, W_BR3, W_BR4, W_CADD, W_BR6};
            default: ;
        endcase
        if (op == 5'b11011) begin
            q.push_back(W_HALT);
            halted   = 1'b1;
            halt_cnt = 0;
            halt_len = directed ? 20 : $urandom_range(1, 25);
        end else begin
            q = {q, W_T0, W_T1, W_T2, W_DEC};
        end
    endtask

    // Directed items: [4:0] op, [5] con value, [6] con forced, [7] clr in LD5.
    logic [7:0] dir_list[$];

    initial begin
        logic [23:0] cur;
        logic [23:0] expw;
        logic [21:0] obs;
        logic [4:0]  op;
        logic [7:0]  item;
        bit          is_dir;
        int          drivers;
        int          n_t0;
        n_checks   = 0;
        n_fail     = 0;
        halted     = 1'b0;
        halt_cnt   = 0;
        halt_len   = 0;
        clr_at_ld5 = 1'b0;
        con_mode   = 0;
        n_t0       = 0;
        dir_list = {8'h00, 8'h02, {3'b011, 5'b10010}, {3'b010, 5'b10010},
                    8'h15, 8'h80, 8'h01, 8'h1A, 8'h1B};

        clr       = 1'b1;
        operation = 5'b0;
        con_ff    = 1'b0;
        @(posedge clk);
        #1;
        clr = 1'b0;
        q   = {W_RST, W_T0, W_T1, W_T2, W_DEC};

        for (int cyc = 0; cyc < 3000; cyc++) begin
            clr = 1'b0;
            if (q.size() == 0) begin
                if (halted) begin
                    q.push_back(W_HALT);
                end else begin
                    check("model_underrun", 32'd1, 32'd0);
                    break;
                end
            end
            cur = q.pop_front();

            // Drive inputs away from the edge; both are don't-care outside
            // DEC / BR6 so they get random values every cycle.
            case (con_mode)
                1: con_ff = 1'b0;
                2: con_ff = 1'b1;
                default: con_ff = 1'($urandom);
            endcase
            operation = 5'($urandom);
            is_dir    = 1'b0;
            op        = operation;
            if (cur[23]) begin
                if (dir_list.size() != 0) begin
                    item       = dir_list.pop_front();
                    is_dir     = 1'b1;
                    op         = item[4:0];
                    con_mode   = item[6] ? (item[5] ? 2 : 1) : 0;
                    clr_at_ld5 = item[7];
                end else begin
                    con_mode = 0;
                    case ($urandom % 8)
                        0: op = 5'b00000;
                        1: op = 5'b00001;
                        2: op = 5'b00010;
                        3: op = 5'b10010;
                        4: op = 5'b11010;
                        5: op = ($urandom % 6 == 0) ? 5'b11011 : 5'($urandom);
                        default: op = 5'($urandom);
                    endcase
                end
                operation = op;
            end
            if (clr_at_ld5 && cur == W_ZMAR) begin
                clr        = 1'b1;
                clr_at_ld5 = 1'b0;
            end
            if (halted && cur == W_HALT) begin
                halt_cnt++;
                if (halt_cnt >= halt_len) clr = 1'b1;
            end
            if (dir_list.size() == 0 && !halted && ($urandom % 150 == 0)) clr = 1'b1;

            #1;
            obs = {run, alu_add, enableCon, Baout, R_out, R_in, Grb, Gra, Cout, ZLowout,
                   ZLowIn, ZHighIn, Yin, IRin, RAM_write_en, Read, MDRout, MDRin, MARin,
                   IncPC, PCin, PCout};
            expw = cur;
            if (cur[22]) expw[1] = con_ff;
            check("ctrl_word", {10'd0, obs}, {10'd0, expw[21:0]});
            drivers = int'(PCout) + int'(ZLowout) + int'(MDRout) + int'(R_out)
                    + int'(Baout) + int'(Cout);
            check("bus_single_driver", {31'd0, drivers <= 1}, 32'd1);
            if (cur == W_T0) n_t0++;

            // Advance the model: clr beats dispatch.
            if (clr) begin
                halted = 1'b0;
                q      = {W_RST, W_T0, W_T1, W_T2, W_DEC};
            end else if (cur[23]) begin
                dispatch(op, is_dir);
            end

            @(posedge clk);
            #1;
        end
        check("saw_many_fetches", {31'd0, n_t0 > 100}, 32'd1);
        check("directed_done", dir_list.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
